// File: rtl/mips_multicycle_ctrl.sv
// Purpose : Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, j).
// Latency : FETCH to next FETCH with no wait states: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.
// Backpr. : FETCH/MEMRD/MEMWR hold on mem_ready=0; a stall longer than WAIT_LIMIT cycles traps to EXC.
//
// Ports:
//   clk, rst_n            - clock; asynchronous active-low reset (all outputs 0, state FETCH)
//   opcode[5:0]           - instruction bits [31:26], sampled in DECODE only
//   mem_ready             - completion strobe for the current memory access
//   PCWrite..RegDst       - 1-bit datapath controls
//   ALUOp/ALUSrcB/PCSource- 2-bit datapath selects
//   Exception, exc_cause  - sticky fault flag and code (01 illegal opcode, 10 memory timeout)
//   state[3:0]            - current state encoding for debug
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       Exception,
  output logic [1:0] exc_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_JUMP   = 4'd9,
    ST_EXC    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     cur_st;
  state_t     nxt_st;
  logic [5:0] op_q;
  logic [7:0] wait_cnt;
  logic [1:0] cause_q;
  logic [1:0] cause_nxt;
  logic       is_mem;
  logic       timeout;

  assign is_mem  = (cur_st == ST_FETCH) || (cur_st == ST_MEMRD) || (cur_st == ST_MEMWR);
  // A completing access (mem_ready=1) on the limit cycle is not a timeout.
  assign timeout = is_mem && !mem_ready && (wait_cnt == LIMIT);

  // Next-state logic. DECODE looks at the live opcode; later states only at op_q.
  always_comb begin
    nxt_st    = cur_st;
    cause_nxt = cause_q;
    case (cur_st)
      ST_FETCH:  if (mem_ready) nxt_st = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_st = ST_MEMADR;
          OP_RTYPE:     nxt_st = ST_EXEC;
          OP_BEQ:       nxt_st = ST_BEQ;
          OP_J:         nxt_st = ST_JUMP;
          default: begin
            nxt_st    = ST_EXC;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: nxt_st = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) nxt_st = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) nxt_st = ST_FETCH;
      ST_EXEC:   nxt_st = ST_RWB;
      ST_MEMWB, ST_RWB, ST_BEQ, ST_JUMP: nxt_st = ST_FETCH;
      ST_EXC:    nxt_st = ST_EXC;
      default: begin
        // Unused encodings 11..15 are treated as a corrupted opcode path.
        nxt_st    = ST_EXC;
        cause_nxt = CAUSE_ILLEGAL;
      end
    endcase
    if (timeout) begin
      nxt_st    = ST_EXC;
      cause_nxt = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st   <= ST_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      cur_st  <= nxt_st;
      cause_q <= cause_nxt;
      if (cur_st == ST_DECODE) op_q <= opcode;
      // Any state change clears the counter, so every memory state starts at 0.
      if (nxt_st != cur_st)           wait_cnt <= '0;
      else if (is_mem && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Moore outputs; gated by rst_n because FETCH (the reset state) drives MemRead=1.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    if (rst_n) begin
      case (cur_st)
        ST_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        ST_DECODE: ALUSrcB = 2'b11;
        ST_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ST_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        ST_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign Exception = rst_n && (cur_st == ST_EXC);
  assign exc_cause = rst_n ? cause_q : CAUSE_NONE;
  assign state     = cur_st;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : directed table-driven checks of mips_multicycle_ctrl plus hand-written
//           sequences for the sticky exception and asynchronous reset mid-access.
// Ports   : none (top-level bench); DUT built with WAIT_LIMIT=4.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       Exception;
  logic [1:0] exc_cause;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .Exception(Exception), .exc_cause(exc_cause), .state(state)
  );

  // Control bundle order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  // ALUSrcA RegWrite RegDst | ALUOp ALUSrcB PCSource
  logic [15:0] ctl_act;
  assign ctl_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                    ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

  localparam logic [15:0] C_ZERO = 16'b0;
  localparam logic [15:0] C_FR   = 16'b1_0_0_1_0_0_1_0_0_0_00_01_00; // FETCH, mem_ready=1
  localparam logic [15:0] C_FN   = 16'b0_0_0_1_0_0_0_0_0_0_00_01_00; // FETCH, mem_ready=0
  localparam logic [15:0] C_DEC  = 16'b0_0_0_0_0_0_0_0_0_0_00_11_00;
  localparam logic [15:0] C_MADR = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
  localparam logic [15:0] C_MRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MWB  = 16'b0_0_0_0_0_1_0_0_1_0_00_00_00;
  localparam logic [15:0] C_MWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_EXEC = 16'b0_0_0_0_0_0_0_1_0_0_10_00_00;
  localparam logic [15:0] C_RWB  = 16'b0_0_0_0_0_0_0_0_1_1_00_00_00;
  localparam logic [15:0] C_BEQ  = 16'b0_1_0_0_0_0_0_1_0_0_01_00_01;
  localparam logic [15:0] C_JMP  = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ex;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [15:0] ctl,
                     input logic ex, input logic [1:0] cause);
    vec_t v;
    v.rst_n = r; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.ex = ex; v.cause = cause;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [15:0] ctl,
                       input logic ex, input logic [1:0] cause);
    n_checks++;
    if (state !== st || ctl_act !== ctl || Exception !== ex || exc_cause !== cause) begin
      n_err++;
      $display("FAIL %s: got state=%0d ctl=%b exc=%b cause=%b, want state=%0d ctl=%b exc=%b cause=%b",
               name, state, ctl_act, Exception, exc_cause, st, ctl, ex, cause);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    add(0, 6'b000000, 1, 0, C_ZERO, 0, 2'd0);
    add(0, 6'b000000, 0, 0, C_ZERO, 0, 2'd0);
    // ---- R-type; opcode garbled after DECODE, mem_ready toggled in non-memory state ----
    add(1, 6'b000000, 1, 0, C_FR,   0, 2'd0);
    add(1, 6'b000000, 1, 1, C_DEC,  0, 2'd0);
    add(1, 6'b111111, 1, 6, C_EXEC, 0, 2'd0);
    add(1, 6'b111111, 0, 7, C_RWB,  0, 2'd0);
    // ---- lw with 3 stall cycles in MEMRD; live opcode says sw after DECODE ----
    add(1, 6'b100011, 1, 0, C_FR,   0, 2'd0);
    add(1, 6'b100011, 1, 1, C_DEC,  0, 2'd0);
    add(1, 6'b101011, 1, 2, C_MADR, 0, 2'd0);
    add(1, 6'b101011, 0, 3, C_MRD,  0, 2'd0);
    add(1, 6'b101011, 0, 3, C_MRD,  0, 2'd0);
    add(1, 6'b101011, 0, 3, C_MRD,  0, 2'd0);
    add(1, 6'b101011, 1, 3, C_MRD,  0, 2'd0);
    add(1, 6'b101011, 0, 4, C_MWB,  0, 2'd0);
    // ---- sw; ready arrives exactly on the limit cycle and must still complete ----
    add(1, 6'b101011, 1, 0, C_FR,   0, 2'd0);
    add(1, 6'b101011, 1, 1, C_DEC,  0, 2'd0);
    add(1, 6'b100011, 1, 2, C_MADR, 0, 2'd0);
    add(1, 6'b100011, 0, 5, C_MWR,  0, 2'd0);
    add(1, 6'b100011, 0, 5, C_MWR,  0, 2'd0);
    add(1, 6'b100011, 0, 5, C_MWR,  0, 2'd0);
    add(1, 6'b100011, 0, 5, C_MWR,  0, 2'd0);
    add(1, 6'b100011, 1, 5, C_MWR,  0, 2'd0);
    // ---- beq then j ----
    add(1, 6'b000100, 1, 0, C_FR,   0, 2'd0);
    add(1, 6'b000100, 1, 1, C_DEC,  0, 2'd0);
    add(1, 6'b000010, 0, 8, C_BEQ,  0, 2'd0);
    add(1, 6'b000010, 1, 0, C_FR,   0, 2'd0);
    add(1, 6'b000010, 1, 1, C_DEC,  0, 2'd0);
    add(1, 6'b000000, 1, 9, C_JMP,  0, 2'd0);
    // ---- FETCH timeout: 5 FETCH cycles with no IRWrite, then EXC cause 10 ----
    for (int i = 0; i < 5; i++) add(1, 6'b000000, 0, 0, C_FN, 0, 2'd0);
    add(1, 6'b000000, 1, 10, C_ZERO, 1, 2'd2);
    add(1, 6'b000000, 0, 10, C_ZERO, 1, 2'd2);
    // ---- reset out of EXC, then illegal opcode ----
    add(0, 6'b000000, 1, 0, C_ZERO, 0, 2'd0);
    add(1, 6'b111111, 1, 0, C_FR,   0, 2'd0);
    add(1, 6'b111111, 1, 1, C_DEC,  0, 2'd0);
    add(1, 6'b000000, 1, 10, C_ZERO, 1, 2'd1);
    add(1, 6'b000000, 0, 10, C_ZERO, 1, 2'd1);

    // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].mr;
      #2;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, vecs[i].ex, vecs[i].cause);
      @(posedge clk); #1;
    end

    // ---- EXC stays terminal for 20 more cycles whatever the inputs ----
    for (int i = 0; i < 20; i++) begin
      opcode    = 6'($urandom);
      mem_ready = 1'(i);
      #2;
      check($sformatf("exc_hold%0d", i), 4'd10, C_ZERO, 1'b1, 2'd1);
      @(posedge clk); #1;
    end

    // ---- asynchronous reset while MEMWR is waiting ----
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    opcode    = 6'b101011;
    mem_ready = 1'b1;
    #1;
    check("sw_fetch", 4'd0, C_FR, 1'b0, 2'd0);
    @(posedge clk); #2;
    check("sw_decode", 4'd1, C_DEC, 1'b0, 2'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    check("sw_memadr", 4'd2, C_MADR, 1'b0, 2'd0);
    @(posedge clk); #2;
    check("sw_memwr_wait", 4'd5, C_MWR, 1'b0, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", 4'd0, C_ZERO, 1'b0, 2'd0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_release_fetch", 4'd0, C_FR, 1'b0, 2'd0);
    @(posedge clk); #2;
    check("rst_first_edge", 4'd1, C_DEC, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, the maximum number of cycles a memory state waits for mem_ready (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory completion strobe for the current access.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, all outputs, 1 bit each, the datapath controls.
REQ-007 SHALL have ports ALUOp, ALUSrcB, PCSource, all outputs, 2 bits each, the datapath selects.
REQ-008 SHALL have port Exception, output, 1, sticky fault flag.
REQ-009 SHALL have port exc_cause, output, 2, fault code: 00 none, 01 illegal opcode, 10 memory timeout.
REQ-010 SHALL have port state, output, 4, current state encoding, for debug.

Function
REQ-011 SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, EXC=10.
- Codes 11..15 SHALL go to EXC with exc_cause 01.
REQ-012 SHALL drive every control output to 0 in any state where this document lists no value for it; no X values are permitted.
REQ-013 SHALL drive these outputs in FETCH:
- MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
- IRWrite=PCWrite=mem_ready (combinational qualification).
REQ-014 SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 in DECODE, and SHALL latch opcode into an internal register on the DECODE→next edge.
- All later states decode the latched copy, never the live opcode.
REQ-015 SHALL drive these outputs in the remaining states:
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR: MemWrite=1, IorD=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
REQ-016 SHALL take the following state transitions:
- FETCH→DECODE when mem_ready=1.
- DECODE→MEMADR on 100011/101011; →EXEC on 000000; →BEQ on 000100; →JUMP on 000010; →EXC with exc_cause=01 on any other opcode.
- MEMADR→MEMRD for lw, →MEMWR for sw.
- MEMRD→MEMWB when mem_ready=1.
- MEMWR→FETCH when mem_ready=1.
- EXEC→RWB.
- MEMWB, RWB, BEQ, JUMP→FETCH.
REQ-017 SHALL make the zero-wait latencies, FETCH to next FETCH: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-018 SHALL hold all outputs of a waiting memory state (FETCH, MEMRD, MEMWR) stable while mem_ready=0.
- Exception: FETCH IRWrite/PCWrite follow REQ-013.
REQ-019 SHALL run an 8-bit wait counter:
- Clears on entry to every memory state.
- Increments each cycle that state is held with mem_ready=0.
- When the counter equals WAIT_LIMIT while mem_ready=0, next state is EXC with exc_cause=10.
- mem_ready=1 in that same cycle wins: the access completes normally.
REQ-020 SHALL keep EXC as a terminal state until reset.
- All control outputs are 0 in EXC.
- Exception=1 from the first EXC cycle onward.
- exc_cause is captured once and holds.
REQ-021 SHALL present mem_ready to a non-memory state with no effect on any output or transition.

Reset
REQ-022 SHALL, while rst_n=0, immediately and asynchronously:
- Force all control outputs, Exception, exc_cause to 0.
- Set state to FETCH.
- Clear the wait counter and the latched opcode.
REQ-023 SHALL, on rst_n assertion mid-instruction (including in EXC or during a wait), abandon that instruction; the first rising edge after release is a normal FETCH cycle.

Verification
REQ-024 SHALL verify R-type flow: mem_ready tied 1, opcode=000000 → states 0,1,6,7,0; RWB shows RegWrite=1, RegDst=1.
REQ-025 SHALL verify lw with memory stall: opcode=100011, mem_ready low 3 cycles in MEMRD → MEMRD lasts 4 cycles with MemRead=1, IorD=1 stable, then MEMWB with RegWrite=1, MemtoReg=1.
REQ-026 SHALL verify illegal opcode: opcode=111111 in DECODE → state 10, Exception=1, exc_cause=01, all controls 0 for 20 further cycles.
REQ-027 SHALL verify timeout: WAIT_LIMIT=4, mem_ready held 0 in FETCH → EXC entered after 5 FETCH cycles, exc_cause=10; IRWrite never asserted.
REQ-028 SHALL verify beq then j: beq → PCWriteCond=1, PCSource=01 in cycle 3; j → PCWrite=1, PCSource=10 in cycle 3; both return to FETCH.
REQ-029 SHALL verify reset mid-operation: rst_n pulsed low during MEMWR → MemWrite drops to 0 without waiting for a clock; after release state=0 with MemRead=1.
